// File: rtl/gated_bus_mux.sv
// Shared data-bus gate multiplexer: strict one-hot or round-robin source selection,
// with contention monitoring and a record of the last driven bus value.
module gated_bus_mux #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NSRC       = 4,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned HOLD_EMPTY = 0
) (
    input  logic                    Clk,
    input  logic                    Reset_ah,
    input  logic [NSRC-1:0]         gate,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [NSRC-1:0]         grant,
    output logic [WIDTH-1:0]        bus_last,
    output logic                    err_sticky,
    output logic [7:0]              err_count,
    output logic [NSRC-1:0]         err_gates
);

    localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    base;
    logic [PW-1:0]    sel_idx;
    logic             sel_found;
    logic             any_gate;
    logic             contention;
    logic [WIDTH-1:0] sel_data;

    // Contention: a second asserted gate seen after a first one.
    always_comb begin
        any_gate   = 1'b0;
        contention = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (gate[i]) begin
                if (any_gate) contention = 1'b1;
                any_gate = 1'b1;
            end
        end
    end

    // One-hot mode searches from index 0, so it finds the lone gate when there is one.
    assign base = (ARB_MODE == 1) ? rr_ptr : '0;

    // Walk downward so the smallest offset from base is the one left selected.
    always_comb begin
        logic [PW-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = int'(NSRC) - 1; k >= 0; k--) begin
            idx = PW'((32'(base) + 32'(k)) % NSRC);
            if (gate[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_data = '0;
        if (sel_found && (ARB_MODE == 1 || !contention)) grant[sel_idx] = 1'b1;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (grant[i]) sel_data = src_data[i*WIDTH +: WIDTH];
        end
    end

    assign bus_valid = |grant;
    assign bus_out   = bus_valid ? sel_data : ((HOLD_EMPTY != 0) ? bus_last : '0);

    // Bus history and arbitration position; untouched by clr_err.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            bus_last <= '0;
            rr_ptr   <= '0;
        end else if (bus_valid) begin
            bus_last <= bus_out;
            rr_ptr   <= (32'(sel_idx) == NSRC - 1) ? '0 : sel_idx + PW'(1);
        end
    end

    // Contention monitor; a contention cycle outranks a simultaneous clear.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            err_gates  <= '0;
        end else if (contention) begin
            if (clr_err)                  err_count <= CW'(1);
            else if (err_count != CNT_MAX) err_count <= err_count + CW'(1);
            if (clr_err || err_count == '0) err_gates <= gate;
            if (ARB_MODE == 0)            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            err_gates  <= '0;
        end
    end

endmodule

// File: tb/tb_gated_bus_mux.sv
// Directed bench for gated_bus_mux: one-hot (zero and hold empty bus) and round-robin
// instances share stimulus and are compared against hand-computed values.
module tb_gated_bus_mux;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    logic             Clk = 1'b0;
    logic             Reset_ah;
    logic [N-1:0]     gate;
    logic [N*W-1:0]   src_data;
    logic             clr_err;

    // Instance 0: one-hot, zero when empty. 1: round-robin. 2: one-hot, hold when empty.
    logic [W-1:0] bo [3];
    logic         bv [3];
    logic [N-1:0] gr [3];
    logic [W-1:0] bl [3];
    logic         es [3];
    logic [7:0]   ec [3];
    logic [N-1:0] eg [3];

    int checks   = 0;
    int failures = 0;

    gated_bus_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(0), .HOLD_EMPTY(0)) u_m0 (
        .Clk(Clk), .Reset_ah(Reset_ah), .gate(gate), .src_data(src_data), .clr_err(clr_err),
        .bus_out(bo[0]), .bus_valid(bv[0]), .grant(gr[0]), .bus_last(bl[0]),
        .err_sticky(es[0]), .err_count(ec[0]), .err_gates(eg[0]));

    gated_bus_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(1), .HOLD_EMPTY(0)) u_m1 (
        .Clk(Clk), .Reset_ah(Reset_ah), .gate(gate), .src_data(src_data), .clr_err(clr_err),
        .bus_out(bo[1]), .bus_valid(bv[1]), .grant(gr[1]), .bus_last(bl[1]),
        .err_sticky(es[1]), .err_count(ec[1]), .err_gates(eg[1]));

    gated_bus_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(0), .HOLD_EMPTY(1)) u_m0h (
        .Clk(Clk), .Reset_ah(Reset_ah), .gate(gate), .src_data(src_data), .clr_err(clr_err),
        .bus_out(bo[2]), .bus_valid(bv[2]), .grant(gr[2]), .bus_last(bl[2]),
        .err_sticky(es[2]), .err_count(ec[2]), .err_gates(eg[2]));

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  gate;
        logic        clr;
        logic [3:0]  g0;
        logic [15:0] b0;
        logic [3:0]  g1;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [15:0] l0;
        logic [15:0] l1;
        logic [7:0]  cnt;
        logic        stk0;
        logic [3:0]  egs;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_ah = 1'b1;
        gate     = '0;
        clr_err  = 1'b0;
        tick();
        Reset_ah = 1'b0;
    endtask

    initial begin
        logic [3:0] rot_exp [6];

        src_data = {16'h4444, 16'h3A5C, 16'h2222, 16'h1111};
        gate     = '0;
        clr_err  = 1'b0;
        Reset_ah = 1'b1;
        #7;
        Reset_ah = 1'b0;
        tick();

        // Reset state
        chk("rst_bus_out", 32'(bo[0]), 32'h0);
        chk("rst_bus_valid", 32'(bv[0]), 32'h0);
        chk("rst_grant", 32'(gr[0]), 32'h0);
        chk("rst_bus_last", 32'(bl[0]), 32'h0);
        chk("rst_err_count", 32'(ec[1]), 32'h0);
        chk("rst_err_gates", 32'(eg[0]), 32'h0);

        //        gate     clr   g0       b0        g1       b1        b2        l0        l1        cnt  stk0  egs
        tbl[0] = '{4'b0100, 1'b0, 4'b0100, 16'h3A5C, 4'b0100, 16'h3A5C, 16'h3A5C, 16'h3A5C, 16'h3A5C, 8'd0, 1'b0, 4'b0000};
        tbl[1] = '{4'b0110, 1'b0, 4'b0000, 16'h0000, 4'b0010, 16'h2222, 16'h3A5C, 16'h3A5C, 16'h2222, 8'd1, 1'b1, 4'b0110};
        tbl[2] = '{4'b0110, 1'b0, 4'b0000, 16'h0000, 4'b0100, 16'h3A5C, 16'h3A5C, 16'h3A5C, 16'h3A5C, 8'd2, 1'b1, 4'b0110};
        tbl[3] = '{4'b0110, 1'b0, 4'b0000, 16'h0000, 4'b0010, 16'h2222, 16'h3A5C, 16'h3A5C, 16'h2222, 8'd3, 1'b1, 4'b0110};
        tbl[4] = '{4'b0000, 1'b0, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 16'h3A5C, 16'h3A5C, 16'h2222, 8'd3, 1'b1, 4'b0110};
        tbl[5] = '{4'b0001, 1'b0, 4'b0001, 16'h1111, 4'b0001, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 8'd3, 1'b1, 4'b0110};
        tbl[6] = '{4'b1000, 1'b1, 4'b1000, 16'h4444, 4'b1000, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 8'd0, 1'b0, 4'b0000};
        tbl[7] = '{4'b1111, 1'b0, 4'b0000, 16'h0000, 4'b0001, 16'h1111, 16'h4444, 16'h4444, 16'h1111, 8'd1, 1'b1, 4'b1111};
        tbl[8] = '{4'b1111, 1'b0, 4'b0000, 16'h0000, 4'b0010, 16'h2222, 16'h4444, 16'h4444, 16'h2222, 8'd2, 1'b1, 4'b1111};

        for (int r = 0; r < 9; r++) begin
            gate    = tbl[r].gate;
            clr_err = tbl[r].clr;
            #1;
            chk($sformatf("v%0d_grant0", r), 32'(gr[0]), 32'(tbl[r].g0));
            chk($sformatf("v%0d_bus0", r), 32'(bo[0]), 32'(tbl[r].b0));
            chk($sformatf("v%0d_valid0", r), 32'(bv[0]), 32'(|tbl[r].g0));
            chk($sformatf("v%0d_grant1", r), 32'(gr[1]), 32'(tbl[r].g1));
            chk($sformatf("v%0d_bus1", r), 32'(bo[1]), 32'(tbl[r].b1));
            chk($sformatf("v%0d_bus2_hold", r), 32'(bo[2]), 32'(tbl[r].b2));
            tick();
            chk($sformatf("v%0d_last0", r), 32'(bl[0]), 32'(tbl[r].l0));
            chk($sformatf("v%0d_last1", r), 32'(bl[1]), 32'(tbl[r].l1));
            chk($sformatf("v%0d_cnt0", r), 32'(ec[0]), 32'(tbl[r].cnt));
            chk($sformatf("v%0d_cnt1", r), 32'(ec[1]), 32'(tbl[r].cnt));
            chk($sformatf("v%0d_sticky0", r), 32'(es[0]), 32'(tbl[r].stk0));
            chk($sformatf("v%0d_sticky1", r), 32'(es[1]), 32'h0);
            chk($sformatf("v%0d_egates0", r), 32'(eg[0]), 32'(tbl[r].egs));
            chk($sformatf("v%0d_egates1", r), 32'(eg[1]), 32'(tbl[r].egs));
        end
        clr_err = 1'b0;

        // Asynchronous reset mid-cycle after five contention cycles
        do_reset();
        gate = 4'b0100;
        tick();
        gate = 4'b0011;
        for (int c = 0; c < 5; c++) tick();
        chk("pre_rst_cnt0", 32'(ec[0]), 32'd5);
        chk("pre_rst_last0", 32'(bl[0]), 32'h3A5C);
        gate = '0;
        #2;
        Reset_ah = 1'b1;
        #1;
        chk("midrst_last0", 32'(bl[0]), 32'h0);
        chk("midrst_cnt0", 32'(ec[0]), 32'h0);
        chk("midrst_sticky0", 32'(es[0]), 32'h0);
        chk("midrst_egates0", 32'(eg[0]), 32'h0);
        chk("midrst_cnt1", 32'(ec[1]), 32'h0);
        chk("midrst_bus0", 32'(bo[0]), 32'h0);
        chk("midrst_bus2", 32'(bo[2]), 32'h0);
        tick();
        Reset_ah = 1'b0;

        // Round-robin rotation restarting from index 0 after reset
        rot_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        gate = 4'b1011;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rot%0d_grant1", c), 32'(gr[1]), 32'(rot_exp[c]));
            chk($sformatf("rot%0d_grant0", c), 32'(gr[0]), 32'h0);
            tick();
        end
        chk("rot_cnt1", 32'(ec[1]), 32'd6);
        chk("rot_sticky1", 32'(es[1]), 32'h0);
        chk("rot_cnt0", 32'(ec[0]), 32'd6);
        chk("rot_sticky0", 32'(es[0]), 32'h1);
        chk("rot_egates0", 32'(eg[0]), 32'hB);

        // Clear together with contention, then clear alone
        gate    = 4'b0011;
        clr_err = 1'b1;
        tick();
        chk("clra_cnt0", 32'(ec[0]), 32'd1);
        chk("clra_sticky0", 32'(es[0]), 32'h1);
        chk("clra_egates0", 32'(eg[0]), 32'h3);
        chk("clra_last0", 32'(bl[0]), 32'h0);
        gate = 4'b0001;
        tick();
        clr_err = 1'b0;
        chk("clrb_cnt0", 32'(ec[0]), 32'h0);
        chk("clrb_sticky0", 32'(es[0]), 32'h0);
        chk("clrb_egates0", 32'(eg[0]), 32'h0);
        chk("clrb_cnt1", 32'(ec[1]), 32'h0);
        chk("clrb_last0", 32'(bl[0]), 32'h1111);

        // Counter saturation; captured gates stay from the first contention
        do_reset();
        gate = 4'b1010;
        tick();
        gate = 4'b0110;
        for (int c = 0; c < 253; c++) tick();
        chk("sat_cnt0_254", 32'(ec[0]), 32'd254);
        for (int c = 0; c < 46; c++) tick();
        chk("sat_cnt0", 32'(ec[0]), 32'd255);
        chk("sat_cnt1", 32'(ec[1]), 32'd255);
        chk("sat_egates0", 32'(eg[0]), 32'hA);
        chk("sat_egates1", 32'(eg[1]), 32'hA);
        chk("sat_sticky0", 32'(es[0]), 32'h1);
        gate = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
